// File: rtl/memshare_regfile_loader_pkg.sv
// Shared memShare regfile geometry defaults and the loader FSM state encoding.
// Imported by the loader so the control wrapper and loader agree on page layout.
package memshare_regfile_loader_pkg;

    localparam int DEFAULT_TYPE0_ADDR_BITWIDTH = 6;
    localparam int DEFAULT_TYPE0_REG_BITWIDTH  = 7;
    localparam int DEFAULT_TYPE0_PAGE_NUM      = 64;
    localparam int DEFAULT_LEN_BITWIDTH        = 7;
    localparam int DEFAULT_DELTA_RST_CYCLE     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/memshare_regfile_loader.sv
// Streams a burst of L1PA shift-pattern pages into the type-0 regfile write port,
// then holds the shift-delta pipeline in reset so no stale delta survives the reload.
module memshare_regfile_loader
    import memshare_regfile_loader_pkg::*;
#(
    parameter int TYPE0_ADDR_BITWIDTH = DEFAULT_TYPE0_ADDR_BITWIDTH,
    parameter int TYPE0_REG_BITWIDTH  = DEFAULT_TYPE0_REG_BITWIDTH,
    parameter int TYPE0_PAGE_NUM      = DEFAULT_TYPE0_PAGE_NUM,
    parameter int LEN_BITWIDTH        = DEFAULT_LEN_BITWIDTH,
    parameter int DELTA_RST_CYCLE     = DEFAULT_DELTA_RST_CYCLE
) (
    input  logic                           sys_clk,
    input  logic                           rstn,
    input  logic                           start_i,
    input  logic [TYPE0_ADDR_BITWIDTH-1:0] base_addr_i,
    input  logic [LEN_BITWIDTH-1:0]        len_i,
    input  logic [TYPE0_REG_BITWIDTH-1:0]  cfg_data_i,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    output logic [TYPE0_ADDR_BITWIDTH-1:0] regType0_waddr_o,
    output logic [TYPE0_REG_BITWIDTH-1:0]  regType0_wdata_o,
    output logic                           regType0_we_o,
    output logic                           deltaPipe_rstn_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    // The flush counter runs DELTA_RST_CYCLE-1 down to 0, one FLUSH cycle per count.
    localparam int CNT_W = (DELTA_RST_CYCLE > 1) ? $clog2(DELTA_RST_CYCLE) : 1;
    localparam logic [CNT_W-1:0]               FLUSH_LOAD = CNT_W'(DELTA_RST_CYCLE - 1);
    localparam logic [TYPE0_ADDR_BITWIDTH-1:0] LAST_PAGE  = TYPE0_ADDR_BITWIDTH'(TYPE0_PAGE_NUM - 1);
    localparam logic [LEN_BITWIDTH-1:0]        MAX_LEN    = LEN_BITWIDTH'(TYPE0_PAGE_NUM);
    localparam logic [LEN_BITWIDTH-1:0]        LEN_ONE    = LEN_BITWIDTH'(1);

    loader_state_e                    state_q, state_d;
    logic [TYPE0_ADDR_BITWIDTH-1:0]   addr_q, addr_d;
    logic [LEN_BITWIDTH-1:0]          remaining_q, remaining_d;
    logic [CNT_W-1:0]                 flush_cnt_q, flush_cnt_d;
    logic                             bad_len_q, bad_len_d;

    logic                             cfg_ready_q, cfg_ready_d;
    logic [TYPE0_ADDR_BITWIDTH-1:0]   waddr_q, waddr_d;
    logic [TYPE0_REG_BITWIDTH-1:0]    wdata_q, wdata_d;
    logic                             we_q, we_d;
    logic                             delta_rstn_q, delta_rstn_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic                             err_q, err_d;

    logic                             beat_acc;
    logic                             len_legal;
    logic [TYPE0_ADDR_BITWIDTH-1:0]   addr_next;

    assign beat_acc  = cfg_valid_i & cfg_ready_q;
    assign len_legal = (len_i != '0) && (len_i <= MAX_LEN);
    // Wrap by compare so non-power-of-two page counts stay inside the regfile.
    assign addr_next = (addr_q == LAST_PAGE) ? '0 : addr_q + TYPE0_ADDR_BITWIDTH'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        flush_cnt_d = flush_cnt_q;
        bad_len_d   = bad_len_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_legal) begin
                        addr_d      = base_addr_i;
                        remaining_d = len_i;
                        bad_len_d   = 1'b0;
                        err_d       = 1'b0;
                        state_d     = ST_LOAD;
                    end else begin
                        bad_len_d   = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                if (beat_acc) begin
                    we_d        = 1'b1;
                    waddr_d     = addr_q;
                    wdata_d     = cfg_data_i;
                    addr_d      = addr_next;
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        flush_cnt_d = FLUSH_LOAD;
                        state_d     = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bad_len_q) begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Ready/busy lead with the next state; flush/done/err trail the state by one
        // cycle, so the last write lands before the delta pipe is pulled low.
        cfg_ready_d  = (state_d == ST_LOAD);
        busy_d       = (state_d != ST_IDLE) || (state_q == ST_DONE);
        delta_rstn_d = (state_q != ST_FLUSH);
        done_d       = (state_q == ST_DONE);
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            flush_cnt_q  <= '0;
            bad_len_q    <= 1'b0;
            cfg_ready_q  <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            delta_rstn_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            flush_cnt_q  <= flush_cnt_d;
            bad_len_q    <= bad_len_d;
            cfg_ready_q  <= cfg_ready_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            delta_rstn_q <= delta_rstn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign cfg_ready_o      = cfg_ready_q;
    assign regType0_waddr_o = waddr_q;
    assign regType0_wdata_o = wdata_q;
    assign regType0_we_o    = we_q;
    assign deltaPipe_rstn_o = delta_rstn_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_memshare_regfile_loader.sv
// Directed bench for the regfile loader: a cycle-scheduled model derived from the
// burst timing rules is compared every cycle, plus literal write logs per scenario.
module tb_memshare_regfile_loader;

    localparam int AW  = 6;
    localparam int DW  = 7;
    localparam int N   = 64;
    localparam int LW  = 7;
    localparam int D   = 2;
    localparam int BIG = 1 << 30;

    logic          sys_clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [LW-1:0] len_i = '0;
    logic [DW-1:0] cfg_data_i = '0;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [AW-1:0] regType0_waddr_o;
    logic [DW-1:0] regType0_wdata_o;
    logic          regType0_we_o;
    logic          deltaPipe_rstn_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    memshare_regfile_loader #(
        .TYPE0_ADDR_BITWIDTH(AW),
        .TYPE0_REG_BITWIDTH (DW),
        .TYPE0_PAGE_NUM     (N),
        .LEN_BITWIDTH       (LW),
        .DELTA_RST_CYCLE    (D)
    ) dut (
        .sys_clk         (sys_clk),
        .rstn            (rstn),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .len_i           (len_i),
        .cfg_data_i      (cfg_data_i),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_ready_o     (cfg_ready_o),
        .regType0_waddr_o(regType0_waddr_o),
        .regType0_wdata_o(regType0_wdata_o),
        .regType0_we_o   (regType0_we_o),
        .deltaPipe_rstn_o(deltaPipe_rstn_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- schedule model ----------------
    int cyc = 0;
    int idle_from = 0;
    int rdy_from = 0, rdy_to = -1;
    int busy_from = 0, busy_to = -1;
    int dl_from = 0, dl_to = -1;
    bit loading = 0;
    int m_base = 0, m_len = 0, m_k = 0;
    bit exp_we[int];
    int exp_addr[int];
    int exp_data[int];
    bit done_at[int];
    bit err_chg[int];

    always @(posedge sys_clk) begin
        int cur;
        cur = cyc;
        if (!rstn) begin
            exp_we.delete(); exp_addr.delete(); exp_data.delete();
            done_at.delete(); err_chg.delete();
            idle_from = cur + 1;
            rdy_to = -1; busy_to = -1; dl_to = -1;
            loading = 0;
        end else if (loading && cur >= rdy_from && cur <= rdy_to && cfg_valid_i) begin
            exp_we[cur+1]   = 1'b1;
            exp_addr[cur+1] = (m_base + m_k) % N;
            exp_data[cur+1] = int'(cfg_data_i);
            m_k++;
            if (m_k == m_len) begin
                rdy_to = cur;
                dl_from = cur + 2;
                dl_to = cur + 1 + D;
                done_at[cur+2+D] = 1'b1;
                busy_to = cur + 2 + D;
                idle_from = cur + 2 + D;
                loading = 0;
            end
        end else if (cur >= idle_from && start_i) begin
            if (int'(len_i) >= 1 && int'(len_i) <= N) begin
                m_base = int'(base_addr_i);
                m_len = int'(len_i);
                m_k = 0;
                loading = 1;
                rdy_from = cur + 1; rdy_to = BIG;
                busy_from = cur + 1; busy_to = BIG;
                idle_from = BIG;
                err_chg[cur+1] = 1'b0;
            end else begin
                err_chg[cur+2] = 1'b1;
                done_at[cur+2] = 1'b1;
                busy_from = cur + 1; busy_to = cur + 2;
                idle_from = cur + 2;
            end
        end
        cyc = cur + 1;
    end

    // ---------------- compare + monitor ----------------
    typedef struct { int addr; int data; } wr_t;
    wr_t wlog[$];
    int done_cnt = 0;
    int dlow_cnt = 0;
    bit err_cur = 0;

    always @(negedge sys_clk) begin
        if (!rstn) begin
            err_cur = 0;
            chk("rst_we", int'(regType0_we_o), 0);
            chk("rst_busy", int'(busy_o), 0);
            chk("rst_ready", int'(cfg_ready_o), 0);
            chk("rst_dprstn", int'(deltaPipe_rstn_o), 1);
            chk("rst_done", int'(done_o), 0);
            chk("rst_err", int'(err_o), 0);
        end else begin
            if (err_chg.exists(cyc)) err_cur = err_chg[cyc];
            chk("we", int'(regType0_we_o), int'(exp_we.exists(cyc)));
            if (exp_we.exists(cyc) && regType0_we_o) begin
                chk("waddr", int'(regType0_waddr_o), exp_addr[cyc]);
                chk("wdata", int'(regType0_wdata_o), exp_data[cyc]);
            end
            chk("ready", int'(cfg_ready_o), int'(cyc >= rdy_from && cyc <= rdy_to));
            chk("busy", int'(busy_o), int'(cyc >= busy_from && cyc <= busy_to));
            chk("dprstn", int'(deltaPipe_rstn_o), int'(!(cyc >= dl_from && cyc <= dl_to)));
            chk("done", int'(done_o), int'(done_at.exists(cyc)));
            chk("err", int'(err_o), int'(err_cur));
            if (regType0_we_o) wlog.push_back('{int'(regType0_waddr_o), int'(regType0_wdata_o)});
            if (done_o) done_cnt++;
            if (!deltaPipe_rstn_o) dlow_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic start_burst(input int base, input int len);
        start_i = 1'b1;
        base_addr_i = AW'(base);
        len_i = LW'(len);
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_beat(input int data, input int gap, input bit poke_start);
        bit acc;
        int n;
        cfg_valid_i = 1'b1;
        cfg_data_i = DW'(data);
        start_i = poke_start;
        n = 0;
        do begin
            acc = cfg_ready_o;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("beat_timeout", 0, 1);
        cfg_valid_i = 1'b0;
        start_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 50) begin
            tick();
            n++;
        end
        if (busy_o) chk("idle_timeout", 0, 1);
        tick();
    endtask

    task automatic clear_log();
        wlog.delete();
        done_cnt = 0;
        dlow_cnt = 0;
    endtask

    task automatic chk_log(input string name, input int idx, input int addr, input int data);
        if (idx < wlog.size()) begin
            chk({name, "_addr"}, wlog[idx].addr, addr);
            if (data >= 0) chk({name, "_data"}, wlog[idx].data, data);
        end else begin
            chk({name, "_missing"}, idx, -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) tick();
        rstn = 1'b1;
        tick();

        // Nominal burst
        clear_log();
        start_burst(5, 3);
        send_beat('h11, 0, 0);
        send_beat('h22, 0, 0);
        send_beat('h33, 0, 0);
        wait_idle();
        chk("nom_nwr", wlog.size(), 3);
        chk_log("nom0", 0, 5, 'h11);
        chk_log("nom1", 1, 6, 'h22);
        chk_log("nom2", 2, 7, 'h33);
        chk("nom_dlow", dlow_cnt, 2);
        chk("nom_done", done_cnt, 1);
        chk("nom_err", int'(err_o), 0);
        $display("TXN nominal base=5 len=3 writes=%0d", wlog.size());

        // Wrap-around
        clear_log();
        start_burst(62, 4);
        for (int i = 0; i < 4; i++) send_beat(i + 1, 0, 0);
        wait_idle();
        chk("wrap_nwr", wlog.size(), 4);
        chk_log("wrap0", 0, 62, 1);
        chk_log("wrap1", 1, 63, 2);
        chk_log("wrap2", 2, 0, 3);
        chk_log("wrap3", 3, 1, 4);
        $display("TXN wrap base=62 len=4 writes=%0d", wlog.size());

        // Valid gaps
        clear_log();
        start_burst(40, 2);
        send_beat('h5A, 2, 0);
        send_beat('h25, 2, 0);
        wait_idle();
        chk("gap_nwr", wlog.size(), 2);
        chk_log("gap0", 0, 40, 'h5A);
        chk_log("gap1", 1, 41, 'h25);
        $display("TXN gaps base=40 len=2 writes=%0d", wlog.size());

        // Illegal lengths 0 and 65
        clear_log();
        start_burst(3, 0);
        tick();
        chk("len0_done_t2", int'(done_o), 1);
        chk("len0_err_t2", int'(err_o), 1);
        wait_idle();
        start_burst(3, 65);
        tick();
        chk("len65_done_t2", int'(done_o), 1);
        chk("len65_err_t2", int'(err_o), 1);
        wait_idle();
        chk("bad_nwr", wlog.size(), 0);
        chk("bad_err_sticky", int'(err_o), 1);
        $display("TXN illegal len=0,65 writes=%0d err=%0d", wlog.size(), err_o);

        // Legal start clears err
        clear_log();
        start_burst(9, 1);
        chk("errclr", int'(err_o), 0);
        send_beat('h01, 0, 0);
        wait_idle();
        chk("errclr_nwr", wlog.size(), 1);
        $display("TXN errclear base=9 len=1 writes=%0d", wlog.size());

        // Valid in IDLE and start mid-LOAD ignored
        clear_log();
        cfg_valid_i = 1'b1;
        cfg_data_i = 'h7F;
        repeat (3) tick();
        cfg_valid_i = 1'b0;
        chk("idlevalid_nwr", wlog.size(), 0);
        start_burst(10, 3);
        send_beat('h0A, 0, 0);
        send_beat('h0B, 0, 1);
        send_beat('h0C, 0, 0);
        wait_idle();
        chk("ign_nwr", wlog.size(), 3);
        chk_log("ign0", 0, 10, 'h0A);
        chk_log("ign2", 2, 12, 'h0C);
        $display("TXN ignore base=10 len=3 writes=%0d", wlog.size());

        // Reset mid-burst
        clear_log();
        start_burst(20, 5);
        send_beat('h31, 0, 0);
        send_beat('h32, 0, 0);
        #1 rstn = 1'b0;
        #1;
        chk("arst_we", int'(regType0_we_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_dprstn", int'(deltaPipe_rstn_o), 1);
        chk("arst_ready", int'(cfg_ready_o), 0);
        repeat (2) @(posedge sys_clk);
        #2 rstn = 1'b1;
        tick();
        start_burst(30, 2);
        send_beat('h41, 0, 0);
        send_beat('h42, 0, 0);
        wait_idle();
        chk("rst_nwr", wlog.size(), 3);
        chk_log("rst0", 0, 20, 'h31);
        chk_log("rst1", 1, 30, 'h41);
        chk_log("rst2", 2, 31, 'h42);
        $display("TXN reset_mid base=20->30 writes=%0d", wlog.size());

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
